// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pulls characters from a standard-read-mode TX FIFO and sends them as
// asynchronous serial frames (start, LSB-first data, optional parity, 1 or 2 stop bits).
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter string       PARITY       = "none",
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] Data,
    input  logic                  Empty,
    input  logic                  Enable,
    output logic                  RdEn,
    output logic                  TxD,
    output logic                  Busy
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW = 3;

    localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [IdxW-1:0] IdxOne   = IdxW'(1);
    localparam logic [IdxW-1:0] LastBit  = IdxW'(DATA_WIDTH - 1);
    localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);

    localparam bit HasParity = (PARITY != "none");
    localparam bit OddParity = (PARITY == "odd");

    // Reject out-of-range configurations while elaborating.
    if (DATA_WIDTH < 5 || DATA_WIDTH > 8) begin : g_bad_width
        $error("uart_tx_serializer: DATA_WIDTH must be in 5..8");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY != "none" && PARITY != "even" && PARITY != "odd") begin : g_bad_parity
        $error("uart_tx_serializer: PARITY must be \"none\", \"even\" or \"odd\"");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    state_e                  state_q;
    logic                    rd_en_q;
    logic                    txd_q;
    logic [CntW-1:0]         cnt_q;     // cycles left in the current bit period
    logic [IdxW-1:0]         idx_q;     // data bit index, reused as stop bit index
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    parity_q;

    // Frame sequencer; every output bit is a flop so TxD never sees a combinational path.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StIdle;
            rd_en_q  <= 1'b0;
            txd_q    <= 1'b1;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    txd_q <= 1'b1;
                    // Enable only gates frame starts; Empty is only looked at here.
                    if (!Empty && Enable) begin
                        state_q <= StFetch;
                        rd_en_q <= 1'b1;
                    end
                end
                StFetch: begin
                    // Read data shows up one cycle after the strobe.
                    state_q <= StLoad;
                end
                StLoad: begin
                    shift_q  <= Data;
                    parity_q <= (^Data) ^ OddParity;
                    txd_q    <= 1'b0;
                    cnt_q    <= CntMax;
                    idx_q    <= '0;
                    state_q  <= StStart;
                end
                StStart: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= CntMax;
                        txd_q   <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StData: begin
                    if (cnt_q == '0) begin
                        cnt_q <= CntMax;
                        if (idx_q == LastBit) begin
                            idx_q <= '0;
                            if (HasParity) begin
                                txd_q   <= parity_q;
                                state_q <= StParity;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            idx_q   <= idx_q + IdxOne;
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StParity: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= CntMax;
                        txd_q   <= 1'b1;
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StStop: begin
                    if (cnt_q == '0) begin
                        if (idx_q == LastStop) begin
                            idx_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            idx_q <= idx_q + IdxOne;
                            cnt_q <= CntMax;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs come straight from state flops.
    always_comb begin
        RdEn = rd_en_q;
        TxD  = txd_q;
        Busy = (state_q != StIdle);
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at 4 clocks per bit: one FIFO-fed instance without
// parity, plus even, odd and two-stop-bit instances sharing one set of inputs.
module tb_uart_tx_serializer;

    localparam int unsigned Cpb = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       plain_reset, plain_enable, plain_empty, plain_rden, plain_txd, plain_busy;
    logic [7:0] plain_data = 8'h00;

    logic       aux_reset, aux_enable, aux_empty;
    logic [7:0] aux_data;
    logic       even_rden, even_txd, even_busy;
    logic       odd_rden, odd_txd, odd_busy;
    logic       stop2_rden, stop2_txd, stop2_busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Standard-read-mode FIFO model feeding the plain instance.
    logic [7:0] fifo_mem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int plain_rd_cnt = 0, plain_busy_cnt = 0, even_rd_cnt = 0, odd_rd_cnt = 0, stop2_rd_cnt = 0;

    always_comb plain_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (plain_rden && (wr_ptr != rd_ptr)) begin
            plain_data <= fifo_mem[rd_ptr % 16];
            rd_ptr     <= rd_ptr + 1;
        end
        if (plain_rden) plain_rd_cnt <= plain_rd_cnt + 1;
        if (plain_busy) plain_busy_cnt <= plain_busy_cnt + 1;
        if (even_rden) even_rd_cnt <= even_rd_cnt + 1;
        if (odd_rden) odd_rd_cnt <= odd_rd_cnt + 1;
        if (stop2_rden) stop2_rd_cnt <= stop2_rd_cnt + 1;
    end

    uart_tx_serializer #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY("none"), .STOP_BITS(1)
    ) u_plain (
        .Clock(clk), .Reset(plain_reset), .Data(plain_data), .Empty(plain_empty),
        .Enable(plain_enable), .RdEn(plain_rden), .TxD(plain_txd), .Busy(plain_busy)
    );

    uart_tx_serializer #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY("even"), .STOP_BITS(1)
    ) u_even (
        .Clock(clk), .Reset(aux_reset), .Data(aux_data), .Empty(aux_empty),
        .Enable(aux_enable), .RdEn(even_rden), .TxD(even_txd), .Busy(even_busy)
    );

    uart_tx_serializer #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY("odd"), .STOP_BITS(1)
    ) u_odd (
        .Clock(clk), .Reset(aux_reset), .Data(aux_data), .Empty(aux_empty),
        .Enable(aux_enable), .RdEn(odd_rden), .TxD(odd_txd), .Busy(odd_busy)
    );

    uart_tx_serializer #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY("none"), .STOP_BITS(2)
    ) u_stop2 (
        .Clock(clk), .Reset(aux_reset), .Data(aux_data), .Empty(aux_empty),
        .Enable(aux_enable), .RdEn(stop2_rden), .TxD(stop2_txd), .Busy(stop2_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr % 16] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Cycles until the plain line goes low (bounded).
    task automatic wait_start(output int n);
        n = 0;
        while (plain_txd !== 1'b0 && n < 30) begin
            tick(1);
            n++;
        end
    endtask

    // Receiver for the plain line: called on start cycle 0, returns on the last stop cycle.
    task automatic rx_frame(input int drop_at, output logic [7:0] d);
        d = '0;
        for (int c = 0; c < 40; c++) begin
            if (c == drop_at) plain_enable = 1'b0;
            if (c % 4 == 2) begin
                if (c / 4 == 0) check("rx_start", plain_txd, 1'b0);
                else if (c / 4 == 9) check("rx_stop", plain_txd, 1'b1);
                else d[c / 4 - 1] = plain_txd;
            end
            if (c < 39) tick(1);
        end
    endtask

    // Expected line waveform: each frame bit held 4 cycles, line at 1 afterwards.
    function automatic logic [63:0] expand(input logic [15:0] bits, input int nbits);
        logic [63:0] w = '1;
        for (int c = 0; c < nbits * 4; c++) w[c] = bits[c / 4];
        return w;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] wave_p, wave_e, wave_o, wave_s;
        logic [7:0]  rx;
        int          cyc, rd0, busy0, e0, o0, s0;
        logic        seen_low;

        plain_reset = 1'b1; aux_reset = 1'b1;
        plain_enable = 1'b0; aux_enable = 1'b0;
        aux_empty = 1'b1; aux_data = 8'h07;
        tick(3);
        check("rst_txd", plain_txd, 1'b1);
        check("rst_busy", plain_busy, 1'b0);
        check("rst_rden", plain_rden, 1'b0);
        check("rst_aux", {even_txd, odd_txd, stop2_txd, even_busy, odd_busy, stop2_busy},
              6'b111000);
        plain_reset = 1'b0; aux_reset = 1'b0;
        tick(2);
        check("idle_busy", plain_busy, 1'b0);

        // 0xA5, no parity: latency and the full line waveform.
        plain_enable = 1'b1;
        rd0 = plain_rd_cnt; busy0 = plain_busy_cnt;
        push(8'hA5);
        tick(1);
        check("lat_rden_c1", plain_rden, 1'b1);
        check("lat_txd_c1", plain_txd, 1'b1);
        tick(1);
        check("lat_rden_c2", plain_rden, 1'b0);
        check("lat_busy_c2", plain_busy, 1'b1);
        tick(1);
        wave_p = '1;
        for (int c = 0; c <= 40; c++) begin
            wave_p[c] = plain_txd;
            if (c < 40) tick(1);
        end
        check("a5_wave", wave_p, expand(16'h034A, 10));
        check("a5_busy_after", plain_busy, 1'b0);
        check("a5_busy_cycles", 64'(plain_busy_cnt - busy0), 64'd42);
        check("a5_rden_pulses", 64'(plain_rd_cnt - rd0), 64'd1);

        // Three queued bytes back to back.
        rd0 = plain_rd_cnt;
        push(8'h00); push(8'hFF); push(8'h55);
        wait_start(cyc);
        check("b_latency", 64'(cyc), 64'd3);
        rx_frame(-1, rx);
        check("b_byte0", rx, 8'h00);
        wait_start(cyc);
        check("b_gap01", 64'(cyc - 1), 64'd3);
        rx_frame(-1, rx);
        check("b_byte1", rx, 8'hFF);
        wait_start(cyc);
        check("b_gap12", 64'(cyc - 1), 64'd3);
        rx_frame(-1, rx);
        check("b_byte2", rx, 8'h55);
        tick(5);
        check("b_rden_pulses", 64'(plain_rd_cnt - rd0), 64'd3);
        check("b_busy_idle", plain_busy, 1'b0);

        // Enable dropped during data bit 2 of the first of two bytes.
        rd0 = plain_rd_cnt;
        push(8'h3C); push(8'hC3);
        wait_start(cyc);
        check("c_latency", 64'(cyc), 64'd3);
        rx_frame(12, rx);
        check("c_byte0", rx, 8'h3C);
        seen_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (plain_txd !== 1'b1) seen_low = 1'b1;
        end
        check("c_line_held", seen_low, 1'b0);
        check("c_rden_held", 64'(plain_rd_cnt - rd0), 64'd1);
        check("c_busy_held", plain_busy, 1'b0);
        plain_enable = 1'b1;
        wait_start(cyc);
        check("c_restart", 64'(cyc), 64'd3);
        rx_frame(-1, rx);
        check("c_byte1", rx, 8'hC3);

        // Reset during data bit 3 of 0x96; 0x5A must follow normally.
        rd0 = plain_rd_cnt;
        push(8'h96); push(8'h5A);
        wait_start(cyc);
        check("d_gap", 64'(cyc - 1), 64'd3);
        tick(17);
        check("d_bit3", plain_txd, 1'b0);
        plain_reset = 1'b1;
        tick(1);
        check("d_rst_txd", plain_txd, 1'b1);
        check("d_rst_busy", plain_busy, 1'b0);
        check("d_rst_rden", plain_rden, 1'b0);
        plain_reset = 1'b0;
        wait_start(cyc);
        check("d_restart", 64'(cyc), 64'd3);
        rx_frame(-1, rx);
        check("d_byte", rx, 8'h5A);
        tick(2);
        check("d_rden_pulses", 64'(plain_rd_cnt - rd0), 64'd2);

        // 0x07 on even, odd and two-stop instances; Empty high again right after the fetch.
        e0 = even_rd_cnt; o0 = odd_rd_cnt; s0 = stop2_rd_cnt;
        aux_enable = 1'b1;
        aux_empty = 1'b0;
        tick(1);
        aux_empty = 1'b1;
        check("aux_fetch", {even_rden, odd_rden, stop2_rden}, 3'b111);
        tick(2);
        wave_e = '1; wave_o = '1; wave_s = '1;
        for (int c = 0; c <= 44; c++) begin
            wave_e[c] = even_txd;
            wave_o[c] = odd_txd;
            wave_s[c] = stop2_txd;
            if (c == 43) check("aux_busy_last", {even_busy, stop2_busy}, 2'b11);
            if (c < 44) tick(1);
        end
        check("even_wave", wave_e, expand(16'h060E, 11));
        check("odd_wave", wave_o, expand(16'h040E, 11));
        check("stop2_wave", wave_s, expand(16'h060E, 11));
        check("aux_busy_end", {even_busy, odd_busy, stop2_busy}, 3'b000);
        tick(10);
        check("even_rden_once", 64'(even_rd_cnt - e0), 64'd1);
        check("odd_rden_once", 64'(odd_rd_cnt - o0), 64'd1);
        check("stop2_rden_once", 64'(stop2_rd_cnt - s0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
